dmem_port_arbiter: RTL and testbench

Arbitrates the single data-memory port between two requesters: the CPU MEM stage and a secondary bus master (UART bootloader / DMA engine).
- CPU has default priority.
- A starvation counter forces a secondary grant after MAX_WAIT consecutive denied cycles, stalling the CPU for one cycle.
- Read data returns one cycle later, tagged to the owning requester.
- Sits between the pipeline's store/load-select logic and dmem.

---
 rtl/dmem_port_arbiter_if.sv | 51 +++++
 rtl/dmem_port_arbiter.sv | 154 +++++++++++++++
 tb/tb_dmem_port_arbiter.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_port_arbiter_if.sv
// Data-memory port bundle shared by the CPU MEM stage, the secondary bus
// master (bootloader / DMA) and the dmem macro.
//   slave  : arbiter view (takes both requests, drives dmem)
//   master : environment view (requesters plus the memory itself)
interface dmem_port_arbiter_if #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 32
);
    // CPU side
    logic              cpu_req;
    logic [3:0]        cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_din;
    logic              cpu_stall;
    logic              cpu_rvalid;
    logic [DATA_W-1:0] cpu_dout;

    // Secondary master side
    logic              sec_req;
    logic [3:0]        sec_we;
    logic [ADDR_W-1:0] sec_addr;
    logic [DATA_W-1:0] sec_din;
    logic              sec_gnt;
    logic              sec_rvalid;
    logic [DATA_W-1:0] sec_dout;

    // dmem side
    logic              mem_en;
    logic [3:0]        mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_din;
    logic [DATA_W-1:0] mem_dout;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_din,
        output cpu_stall, cpu_rvalid, cpu_dout,
        input  sec_req, sec_we, sec_addr, sec_din,
        output sec_gnt, sec_rvalid, sec_dout,
        output mem_en, mem_we, mem_addr, mem_din,
        input  mem_dout
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_din,
        input  cpu_stall, cpu_rvalid, cpu_dout,
        output sec_req, sec_we, sec_addr, sec_din,
        input  sec_gnt, sec_rvalid, sec_dout,
        input  mem_en, mem_we, mem_addr, mem_din,
        output mem_dout
    );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Single data-memory port arbiter: CPU has default priority, the secondary
// master gets a forced one-cycle grant after MAX_WAIT consecutive denials.
// Grants are combinational; read data comes back one cycle later, tagged to
// the requester that issued the read.
// Optional statistics counters are built only when ARB_STATS_EN is defined;
// otherwise stat_* outputs are tied to zero.
module dmem_port_arbiter #(
    parameter int ADDR_W   = 14,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 8
) (
    input  logic                clk,
    input  logic                rst,
    dmem_port_arbiter_if.slave  bus,
    output logic [31:0]         stat_sec_grants,
    output logic [31:0]         stat_cpu_stalls
);
    // Last value wait_cnt may reach; hitting it on a denied cycle forces
    // the next cycle to the secondary master.
    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    typedef enum logic {
        CPU_PRI   = 1'b0,
        SEC_FORCE = 1'b1
    } state_t;

    state_t            state, state_nx;
    logic [7:0]        wait_cnt;
    logic              cpu_gnt;
    logic              sec_gnt;
    logic              cpu_stall;
    logic              force_entry;

    // rd_owner: which requester owns the data returning from dmem next cycle
    logic              rd_cpu;
    logic              rd_sec;
    logic [DATA_W-1:0] cpu_hold;
    logic [DATA_W-1:0] sec_hold;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_din;
    logic [3:0]        sel_we;

    // Arbitration state register
    always_ff @(posedge clk) begin
        if (rst) state <= CPU_PRI;
        else     state <= state_nx;
    end

    // Grant decision and next state
    always_comb begin
        cpu_gnt   = 1'b0;
        sec_gnt   = 1'b0;
        cpu_stall = 1'b0;
        state_nx  = state;
        case (state)
            CPU_PRI: begin
                cpu_gnt = bus.cpu_req;
                sec_gnt = bus.sec_req & ~bus.cpu_req;
                if (bus.sec_req && !sec_gnt && (wait_cnt == WAIT_LAST))
                    state_nx = SEC_FORCE;
            end
            SEC_FORCE: begin
                // Forced slot: CPU is held even if the secondary request
                // has already gone away, and we always hand back next cycle.
                sec_gnt   = bus.sec_req;
                cpu_stall = bus.cpu_req;
                state_nx  = CPU_PRI;
            end
            default: state_nx = CPU_PRI;
        endcase
    end

    assign force_entry = (state == CPU_PRI) && (state_nx == SEC_FORCE);

    // Starvation counter: counts consecutive denied secondary cycles
    always_ff @(posedge clk) begin
        if (rst)
            wait_cnt <= 8'd0;
        else if (sec_gnt || !bus.sec_req || force_entry)
            wait_cnt <= 8'd0;
        else if (wait_cnt != WAIT_LAST)
            wait_cnt <= wait_cnt + 8'd1;
    end

    // Port mux: secondary only when granted, otherwise CPU inputs pass through
    always_comb begin
        sel_addr = bus.cpu_addr;
        sel_din  = bus.cpu_din;
        sel_we   = cpu_gnt ? bus.cpu_we : 4'b0000;
        if (sec_gnt) begin
            sel_addr = bus.sec_addr;
            sel_din  = bus.sec_din;
            sel_we   = bus.sec_we;
        end
    end

    assign bus.mem_en    = cpu_gnt | sec_gnt;
    assign bus.mem_we    = sel_we;
    assign bus.mem_addr  = sel_addr;
    assign bus.mem_din   = sel_din;
    assign bus.cpu_stall = cpu_stall;
    assign bus.sec_gnt   = sec_gnt;

    // Tag granted reads with their owner for the return cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_cpu <= 1'b0;
            rd_sec <= 1'b0;
        end else begin
            rd_cpu <= cpu_gnt & (bus.cpu_we == 4'b0000);
            rd_sec <= sec_gnt & (bus.sec_we == 4'b0000);
        end
    end

    // Capture returned data so each dout holds between its own reads
    always_ff @(posedge clk) begin
        if (rst) begin
            cpu_hold <= '0;
            sec_hold <= '0;
        end else begin
            if (rd_cpu) cpu_hold <= bus.mem_dout;
            if (rd_sec) sec_hold <= bus.mem_dout;
        end
    end

    // A read in flight when rst arrives is dropped, so rvalid is masked too
    assign bus.cpu_rvalid = rd_cpu & ~rst;
    assign bus.sec_rvalid = rd_sec & ~rst;
    assign bus.cpu_dout   = rd_cpu ? bus.mem_dout : cpu_hold;
    assign bus.sec_dout   = rd_sec ? bus.mem_dout : sec_hold;

`ifdef ARB_STATS_EN
    logic [31:0] sec_grant_cnt;
    logic [31:0] cpu_stall_cnt;

    // Wrapping event counters for secondary grants and CPU stall cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            sec_grant_cnt <= 32'd0;
            cpu_stall_cnt <= 32'd0;
        end else begin
            if (sec_gnt)   sec_grant_cnt <= sec_grant_cnt + 32'd1;
            if (cpu_stall) cpu_stall_cnt <= cpu_stall_cnt + 32'd1;
        end
    end

    assign stat_sec_grants = sec_grant_cnt;
    assign stat_cpu_stalls = cpu_stall_cnt;
`else
    assign stat_sec_grants = 32'd0;
    assign stat_cpu_stalls = 32'd0;
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Scoreboard bench for dmem_port_arbiter: stimulus runs a request-level
// reference model and queues expected grants/read data; a negedge monitor
// pops and compares. The bench also plays the 1-cycle dmem.
module tb_dmem_port_arbiter;
    localparam int ADDR_W   = 14;
    localparam int DATA_W   = 32;
    localparam int MAX_WAIT = 8;
`ifdef ARB_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    typedef struct {
        bit          stall;
        bit          sgnt;
        bit          en;
        logic [3:0]  we;
        logic [13:0] addr;
        logic [31:0] din;
    } exp_t;

    typedef struct {
        int          cyc;
        logic [31:0] data;
    } rd_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] stat_sec_grants;
    logic [31:0] stat_cpu_stalls;

    dmem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    dmem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT)) dut (
        .clk             (clk),
        .rst             (rst),
        .bus             (bus.slave),
        .stat_sec_grants (stat_sec_grants),
        .stat_cpu_stalls (stat_cpu_stalls)
    );

    always #5 clk = ~clk;

    // dmem stand-in: byte-enabled write, 1-cycle synchronous read
    logic [31:0] dmem    [0:16383];
    logic [31:0] ref_mem [0:16383];
    always @(posedge clk) begin
        if (bus.mem_en) begin
            for (int b = 0; b < 4; b++)
                if (bus.mem_we[b]) dmem[bus.mem_addr][8*b +: 8] <= bus.mem_din[8*b +: 8];
            bus.mem_dout <= dmem[bus.mem_addr];
        end
    end

    exp_t gnt_q[$];
    rd_t  cpu_rd_q[$];
    rd_t  sec_rd_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   denied   = 0;
    bit   force_now = 1'b0;
    bit   last_sgnt = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // One bus cycle: drive inputs, advance the reference model, queue expectations
    task automatic step(input bit r,
                        input bit cr, input logic [3:0] cwe, input logic [13:0] ca, input logic [31:0] cd,
                        input bit sr, input logic [3:0] swe, input logic [13:0] sa, input logic [31:0] sd);
        exp_t e;
        bit   cg, sg;
        cyc++;
        rst = r;
        bus.cpu_req = cr; bus.cpu_we = cwe; bus.cpu_addr = ca; bus.cpu_din = cd;
        bus.sec_req = sr; bus.sec_we = swe; bus.sec_addr = sa; bus.sec_din = sd;
        last_sgnt = 1'b0;
        if (r) begin
            denied = 0;
            force_now = 1'b0;
            cpu_rd_q.delete();
            sec_rd_q.delete();
        end else begin
            if (force_now) begin
                cg = 1'b0; sg = sr; e.stall = cr;
                force_now = 1'b0; denied = 0;
            end else begin
                cg = cr; sg = sr && !cr; e.stall = 1'b0;
                if (sr && !sg) begin
                    denied++;
                    if (denied == MAX_WAIT) begin force_now = 1'b1; denied = 0; end
                end else begin
                    denied = 0;
                end
            end
            e.sgnt = sg;
            e.en   = cg || sg;
            e.we   = sg ? swe : (cg ? cwe : 4'b0000);
            e.addr = sg ? sa : ca;
            e.din  = sg ? sd : cd;
            if (sg && swe == 4'b0000) sec_rd_q.push_back('{cyc, ref_mem[sa]});
            if (cg && cwe == 4'b0000) cpu_rd_q.push_back('{cyc, ref_mem[ca]});
            if (e.en)
                for (int b = 0; b < 4; b++)
                    if (e.we[b]) ref_mem[e.addr][8*b +: 8] = e.din[8*b +: 8];
            gnt_q.push_back(e);
            last_sgnt = sg;
        end
        @(posedge clk); #1;
    endtask

    task automatic idle(input bit r);
        step(r, 1'b0, 4'h0, 14'h0, 32'h0, 1'b0, 4'h0, 14'h0, 32'h0);
    endtask

    function automatic logic [3:0] rand_we();
        if ($urandom_range(0, 1) == 0) return 4'h0;
        return 4'($urandom_range(1, 15));
    endfunction

    // Monitor: compare DUT against queued expectations once per cycle
    int          m_sec = 0, m_stall = 0;
    logic [31:0] last_cpu = '0, last_sec = '0;
    always @(negedge clk) begin
        exp_t e;
        rd_t  rd;
        if (rst) begin
            chk("cpu_rvalid_in_rst", {31'd0, bus.cpu_rvalid}, 32'd0);
            chk("sec_rvalid_in_rst", {31'd0, bus.sec_rvalid}, 32'd0);
            m_sec = 0; m_stall = 0; last_cpu = '0; last_sec = '0;
        end else begin
            chk("stat_sec_grants", stat_sec_grants, STATS ? 32'(m_sec) : 32'd0);
            chk("stat_cpu_stalls", stat_cpu_stalls, STATS ? 32'(m_stall) : 32'd0);
            if (gnt_q.size() == 0) begin
                chk("gnt_q_underflow", 32'd1, 32'd0);
            end else begin
                e = gnt_q.pop_front();
                chk("cpu_stall", {31'd0, bus.cpu_stall}, {31'd0, e.stall});
                chk("sec_gnt",   {31'd0, bus.sec_gnt},   {31'd0, e.sgnt});
                chk("mem_en",    {31'd0, bus.mem_en},    {31'd0, e.en});
                chk("mem_we",    {28'd0, bus.mem_we},    {28'd0, e.we});
                if (e.en) begin
                    chk("mem_addr", {18'd0, bus.mem_addr}, {18'd0, e.addr});
                    chk("mem_din",  bus.mem_din, e.din);
                end
                m_sec   += int'(e.sgnt);
                m_stall += int'(e.stall);
            end
            if (bus.cpu_rvalid) begin
                if (cpu_rd_q.size() == 0) chk("cpu_rvalid_unexpected", 32'd1, 32'd0);
                else begin
                    rd = cpu_rd_q.pop_front();
                    chk("cpu_rd_latency", 32'(rd.cyc + 1), 32'(cyc));
                    chk("cpu_dout", bus.cpu_dout, rd.data);
                    last_cpu = rd.data;
                end
            end else begin
                chk("cpu_dout_hold", bus.cpu_dout, last_cpu);
                if (cpu_rd_q.size() > 0 && cpu_rd_q[0].cyc < cyc) begin
                    chk("cpu_rvalid_missing", 32'd0, 32'd1);
                    void'(cpu_rd_q.pop_front());
                end
            end
            if (bus.sec_rvalid) begin
                if (sec_rd_q.size() == 0) chk("sec_rvalid_unexpected", 32'd1, 32'd0);
                else begin
                    rd = sec_rd_q.pop_front();
                    chk("sec_rd_latency", 32'(rd.cyc + 1), 32'(cyc));
                    chk("sec_dout", bus.sec_dout, rd.data);
                    last_sec = rd.data;
                end
            end else begin
                chk("sec_dout_hold", bus.sec_dout, last_sec);
                if (sec_rd_q.size() > 0 && sec_rd_q[0].cyc < cyc) begin
                    chk("sec_rvalid_missing", 32'd0, 32'd1);
                    void'(sec_rd_q.pop_front());
                end
            end
        end
    end

    initial begin
        bit          sp;
        bit          cr;
        logic [3:0]  cwe, swe;
        logic [13:0] ca, sa;
        logic [31:0] cd, sd;

        bus.cpu_req = 1'b0; bus.cpu_we = '0; bus.cpu_addr = '0; bus.cpu_din = '0;
        bus.sec_req = 1'b0; bus.sec_we = '0; bus.sec_addr = '0; bus.sec_din = '0;
        bus.mem_dout = '0;
        for (int i = 0; i < 64; i++) begin
            dmem[i]    = 32'(i) * 32'h9E3779B1 ^ 32'h5A5A0000;
            ref_mem[i] = 32'(i) * 32'h9E3779B1 ^ 32'h5A5A0000;
        end
        dmem[16]    = 32'hDEADBEEF;
        ref_mem[16] = 32'hDEADBEEF;

        @(posedge clk); #1;
        idle(1'b1); idle(1'b1);
        idle(1'b0); idle(1'b0);

        // Secondary read with CPU idle: same-cycle grant, data next cycle
        step(0, 0, 4'h0, 14'h0, 32'h0, 1, 4'h0, 14'h0010, 32'h0);
        idle(1'b0);

        // CPU write wins over a pending secondary read, then secondary goes
        step(0, 1, 4'b0011, 14'h0004, 32'h1234ABCD, 1, 4'h0, 14'h0005, 32'h0);
        step(0, 0, 4'h0, 14'h0, 32'h0, 1, 4'h0, 14'h0005, 32'h0);
        // Read back the partially written word
        step(0, 1, 4'h0, 14'h0004, 32'h0, 0, 4'h0, 14'h0, 32'h0);

        // Back-to-back CPU reads
        step(0, 1, 4'h0, 14'h0001, 32'h0, 0, 4'h0, 14'h0, 32'h0);
        step(0, 1, 4'h0, 14'h0002, 32'h0, 0, 4'h0, 14'h0, 32'h0);
        idle(1'b0);

        // Build up wait_cnt, end with a granted CPU read, then reset mid-return
        for (int i = 0; i < 3; i++)
            step(0, 1, 4'h0, 14'(3 + i), 32'h0, 1, 4'h0, 14'h0009, 32'h0);
        idle(1'b1);

        // Saturated contention for 27 cycles: forced grants at 8, 17, 26
        sa = 14'h0020; swe = 4'h0; sd = 32'h0;
        for (int i = 0; i < 27; i++) begin
            step(0, 1, 4'h0, 14'(i % 32), 32'h0, 1, swe, sa, sd);
            if (last_sgnt) begin
                sa  = 14'($urandom_range(0, 31));
                swe = rand_we();
                sd  = $urandom;
            end
        end
        chk("stat_sec_after_27", stat_sec_grants, STATS ? 32'd3 : 32'd0);
        chk("stat_stall_after_27", stat_cpu_stalls, STATS ? 32'd3 : 32'd0);

        // Randomized traffic; secondary holds its request until granted
        sp = 1'b0; swe = '0; sa = '0; sd = '0;
        for (int i = 0; i < 600; i++) begin
            if (!sp && $urandom_range(0, 2) == 0) begin
                sp  = 1'b1;
                swe = rand_we();
                sa  = 14'($urandom_range(0, 31));
                sd  = $urandom;
            end
            cr  = (i < 300) ? ($urandom_range(0, 9) < 7) : ($urandom_range(0, 19) != 0);
            cwe = rand_we();
            ca  = 14'($urandom_range(0, 31));
            cd  = $urandom;
            step(0, cr, cwe, ca, cd, sp, swe, sa, sd);
            if (last_sgnt) sp = 1'b0;
        end

        idle(1'b0); idle(1'b0); idle(1'b0);
        chk("gnt_q_drained",    32'(gnt_q.size()),    32'd0);
        chk("cpu_rd_q_drained", 32'(cpu_rd_q.size()), 32'd0);
        chk("sec_rd_q_drained", 32'(sec_rd_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
